// File: rtl/core_run_monitor_pkg.sv
// Shared state encodings and counter widths for the core run monitor.
package core_run_monitor_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int CYCLE_W = 32;

endpackage

// File: rtl/core_run_monitor_if.sv
// Pin/status bundle between the monitored core environment and the run monitor.
interface core_run_monitor_if #(
  parameter int N_PINS = 4,
  parameter int CNT_W  = 16
);
  logic [N_PINS-1:0]       pins_i;
  logic [N_PINS-1:0]       expect_mask_i;
  logic                    core_reset_o;
  logic [1:0]              state_o;
  logic [31:0]             cycle_count_o;
  logic [N_PINS*CNT_W-1:0] toggle_count_o;
  logic                    done_o;
  logic                    pass_o;
  logic                    timeout_o;

  modport master (
    output pins_i, expect_mask_i,
    input  core_reset_o, state_o, cycle_count_o, toggle_count_o,
    input  done_o, pass_o, timeout_o
  );

  modport slave (
    input  pins_i, expect_mask_i,
    output core_reset_o, state_o, cycle_count_o, toggle_count_o,
    output done_o, pass_o, timeout_o
  );
endinterface

// File: rtl/core_run_monitor_pin_toggle_counter.sv
// One monitored pin: edge detect against the previous sample and a saturating toggle count.
module pin_toggle_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             capture_i,
  input  logic             pin_i,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] count_next_o
);
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    prev_d  = prev_q;
    count_d = count_q;
    // capture sets the baseline so a pin already high on entry is not a toggle
    if (en_i || capture_i) prev_d = pin_i;
    if (en_i && (pin_i != prev_q) && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q  <= 1'b0;
      count_q <= '0;
    end else begin
      prev_q  <= prev_d;
      count_q <= count_d;
    end
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;
endmodule

// File: rtl/core_run_monitor.sv
// Run controller: sequences core reset, counts pin toggles, and latches pass or timeout.
module core_run_monitor
  import core_run_monitor_pkg::*;
#(
  parameter int N_PINS         = 4,
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 4000,
  parameter int MIN_TOGGLES    = 2,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  core_run_monitor_if.slave    bus
);
  state_e               state_q, state_d;
  logic [CYCLE_W-1:0]   hold_q, hold_d;
  logic [CYCLE_W-1:0]   cycle_q, cycle_d;
  logic                 core_reset_q, core_reset_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 timeout_q, timeout_d;
  logic                 run_en, capture;
  logic [N_PINS-1:0]    pin_met;
  logic [N_PINS*CNT_W-1:0] cnt_flat, cnt_next_flat;

  assign run_en = (state_q == ST_RUN);

  for (genvar g = 0; g < N_PINS; g++) begin : g_pin
    pin_toggle_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk          (clk),
      .reset        (reset),
      .en_i         (run_en),
      .capture_i    (capture),
      .pin_i        (bus.pins_i[g]),
      .count_o      (cnt_flat[g*CNT_W +: CNT_W]),
      .count_next_o (cnt_next_flat[g*CNT_W +: CNT_W])
    );
    // completion looks at the counts this edge will produce, not the current ones
    assign pin_met[g] = ~bus.expect_mask_i[g] |
                        (cnt_next_flat[g*CNT_W +: CNT_W] >= CNT_W'(MIN_TOGGLES));
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    cycle_d      = cycle_q;
    core_reset_d = core_reset_q;
    done_d       = done_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    capture      = 1'b0;
    case (state_q)
      ST_RUN: begin
        cycle_d = cycle_q + CYCLE_W'(1);
        if (&pin_met) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end else if (cycle_d == CYCLE_W'(TIMEOUT_CYCLES)) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      ST_DONE: ;
      default: begin
        state_d = ST_HOLD;
        hold_d  = hold_q + CYCLE_W'(1);
        if (hold_q == CYCLE_W'(RESET_CYCLES - 1)) begin
          state_d      = ST_RUN;
          core_reset_d = 1'b0;
          capture      = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_HOLD;
      hold_q       <= '0;
      cycle_q      <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cycle_q      <= cycle_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.core_reset_o   = core_reset_q;
  assign bus.state_o        = state_q;
  assign bus.cycle_count_o  = cycle_q;
  assign bus.toggle_count_o = cnt_flat;
  assign bus.done_o         = done_q;
  assign bus.pass_o         = pass_q;
  assign bus.timeout_o      = timeout_q;
endmodule

// File: doc/core_run_monitor.md
# core_run_monitor

Synthesizable run controller and pin monitor for the RISC-V top. It sequences the core's reset after board or bench reset, then watches N core output pins (LEDs, D-pins) for toggles. It declares pass when every expected pin has toggled enough times, or timeout after a fixed cycle budget. This replaces the fixed-length, reset-less bench run with a parametrised, self-checking block that can sit in the bench and on hardware, driving a status LED.

## Interface
- N_PINS, 4, number of monitored pins
- RESET_CYCLES, 4, cycles core_reset_o is held after reset release (≥1)
- TIMEOUT_CYCLES, 4000, RUN-cycle budget before timeout (≥1, < 2^32)
- MIN_TOGGLES, 2, toggles required on each expected pin (≥1, ≤ 2^CNT_W−1)
- CNT_W, 16, width of each per-pin toggle counter
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- pins_i  in  N_PINS  core output pins, same clock domain, no synchronizer
- expect_mask_i  in  N_PINS  pins that must reach MIN_TOGGLES; quasi-static
- core_reset_o  out  1  active-high reset to the core
- state_o  out  2  current FSM state
- cycle_count_o  out  32  RUN cycles elapsed
- toggle_count_o  out  N_PINS*CNT_W  per-pin toggle counts; pin i at [i*CNT_W +: CNT_W]
- done_o  out  1  run finished (sticky)
- pass_o  out  1  finished by pass (sticky)
- timeout_o  out  1  finished by timeout (sticky)

## Operation
- States: HOLD=0, RUN=1, DONE=2. Encoding 3 is unreachable and decodes to HOLD.
- Reset values: state HOLD, core_reset_o=1, cycle_count_o=0, all toggle counts 0, done_o=pass_o=timeout_o=0, hold counter 0.
- HOLD: hold counter increments each cycle. On the edge where it equals RESET_CYCLES−1: go to RUN, core_reset_o←0, pins_prev←pins_i (baseline capture; a pin already high does not count as a toggle).
- RUN, each edge:
  - cycle_count +1.
  - For each pin with pins_i≠pins_prev, toggle count +1, saturating at 2^CNT_W−1.
  - pins_prev←pins_i.
- Completion is evaluated on the updated (next) values in the same edge:
  - If every pin in expect_mask_i has next toggle count ≥ MIN_TOGGLES: go to DONE with done_o=pass_o=1.
  - Else, if next cycle_count == TIMEOUT_CYCLES: go to DONE with done_o=timeout_o=1.
  - If pass and timeout occur on the same edge, pass wins and timeout_o stays 0.
  - expect_mask_i all zero passes on the first RUN edge (cycle_count_o=1).
- DONE: all counters frozen; flags held; core_reset_o stays 0 so the core keeps running. Only reset leaves DONE.
- Reset asserted in any state, including mid-RUN, returns to the reset values on the next edge. The hold sequence then restarts once reset drops.
- Unmasked pins are still counted.

## Timing
- Reset deasserted before edge 0 means core_reset_o is high during cycles 0..RESET_CYCLES−1 and low from cycle RESET_CYCLES; state_o=RUN from that cycle.
- All outputs are registered; no combinational paths from input to output.
- A pin change at input before RUN edge k is reflected in toggle_count_o and cycle_count_o=k after edge k. done_o rises after that same edge (latency 1).
- Single-cycle pulses on pins_i count as two toggles.

## Structure
- Package/include core_run_monitor_pkg: state encodings (ST_HOLD, ST_RUN, ST_DONE) and the 32-bit cycle counter width.
- Sub-module pin_toggle_counter (parameter CNT_W): edge detect, saturating counter, enable (RUN) and clear (reset). Instantiated N_PINS times via generate.
- Top-level FSM, hold counter, cycle counter and pass/timeout reduction stay in core_run_monitor.

## Test plan
- Reset sequencing: RESET_CYCLES=4, reset high 3 cycles then low → core_reset_o high exactly 4 cycles after release, state_o=1 on the 5th; all outputs at reset values during reset.
- Pass: mask 4'b0011, MIN_TOGGLES=2; pin0 toggles at RUN cycles 3 and 7, pin1 at 5 and 9 → done_o=pass_o=1 after edge 9, cycle_count_o=9, counts frozen thereafter.
- Timeout: TIMEOUT_CYCLES=20, no toggles, pin1 held high from HOLD → timeout_o=1 at cycle_count_o=20, pass_o=0, toggle counts all 0 (baseline not counted).
- Simultaneous: TIMEOUT_CYCLES=20, final required toggle lands on RUN cycle 20 → pass_o=1, timeout_o=0.
- Saturation: CNT_W=3, unmasked pin2 toggles every cycle for 12 cycles → toggle_count for pin2 is 7, no wrap.
- Reset mid-run: reset pulse at RUN cycle 10 → next edge all counts 0, flags 0, core_reset_o=1; hold repeats for RESET_CYCLES, then a fresh RUN from cycle_count_o=0.
